csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Sequencer that owns the single write port and the read-address port of the machine-mode CSR file. It arbitrates between software CSR accesses (csrrw/csrrs/... from EXU) and hardware trap entry (ecall/exception) or mret. Trap entry and return are serialised into multi-cycle CSR update sequences, ending in a one-cycle PC redirect to IFU.

Parameters:
MTVEC_ADDR, 12'h305, CSR address of mtvec
MEPC_ADDR, 12'h341, CSR address of mepc
MCAUSE_ADDR, 12'h342, CSR address of mcause
MSTATUS_ADDR, 12'h300, CSR address of mstatus

Ports:
wr_clk  in  1  clock; same clock as the CSR file write port
rst  in  1  synchronous active-high reset
trap_req  in  1  exception/ecall request; sampled only when ready=1
trap_pc  in  32  PC of the trapping instruction
trap_cause  in  32  mcause value to record
mret_req  in  1  mret request; sampled only when ready=1
sw_wr_en  in  1  software CSR write enable
sw_wr_reg  in  12  software CSR write address
sw_wr_bus  in  32  software CSR write data
sw_rd_reg  in  12  software CSR read address
sw_rd_bus  out  32  software CSR read data, equals csr_rd_bus
ready  out  1  1 only in IDLE; requests and software writes accepted only then
csr_wr_en  out  1  to CSR file wr_en
csr_wr_reg  out  12  to CSR file wr_reg
csr_wr_bus  out  32  to CSR file wr_bus
csr_rd_reg  out  12  to CSR file rd_reg
csr_rd_bus  in  32  from CSR file rd_bus (combinational read)
redirect_valid  out  1  one-cycle pulse: fetch from redirect_pc
redirect_pc  out  32  redirect target

Behaviour:
- Reset rst, synchronous, active-high; clock wr_clk. Reset -> state IDLE, latched pc/cause cleared to 0; during and after reset: ready=1, csr_wr_en=0, redirect_valid=0, redirect_pc=0.
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_REDIR, M_STATUS, M_REDIR.
- All csr_* and redirect outputs are combinational from state, latched registers and csr_rd_bus; CSR file commits writes at the next wr_clk edge, so a read in the following state sees the new value.
- IDLE: passthrough: csr_wr_en=sw_wr_en, csr_wr_reg=sw_wr_reg, csr_wr_bus=sw_wr_bus, csr_rd_reg=sw_rd_reg.
  - trap_req=1: latch trap_pc, trap_cause; next T_EPC.
  - else mret_req=1: next M_STATUS.
  - trap_req and mret_req both 1: trap wins; mret dropped (requester must reissue).
  - sw_wr_en together with trap_req/mret_req in IDLE: software write still committed this cycle (older instruction); sequence starts next cycle.
- Non-IDLE states: ready=0; sw_wr_en ignored (no CSR write from software); sw_rd_bus reflects FSM's csr_rd_reg, not sw_rd_reg.
- T_EPC: write mepc=latched pc -> T_CAUSE.
- T_CAUSE: write mcause=latched cause -> T_STATUS.
- T_STATUS: csr_rd_reg=mstatus; write mstatus = old with bit7(MPIE)=old bit3(MIE), bit3(MIE)=0, bits12:11(MPP)=2'b11, all other bits preserved -> T_REDIR.
- T_REDIR: csr_rd_reg=mtvec; redirect_valid=1, redirect_pc={csr_rd_bus[31:2],2'b00} (direct mode only; mode bits ignored); csr_wr_en=0 -> IDLE.
- M_STATUS: csr_rd_reg=mstatus; write mstatus = old with MIE=old MPIE, MPIE=1, MPP=2'b11, others preserved -> M_REDIR.
- M_REDIR: csr_rd_reg=mepc; redirect_valid=1, redirect_pc=csr_rd_bus; no write -> IDLE.
- Latency: trap accepted cycle 0 -> redirect_valid in cycle 4; mret accepted cycle 0 -> redirect_valid in cycle 2. Back-to-back: new request accepted earliest the cycle after the REDIR state.
- redirect_valid=0 and redirect_pc=0 in all states except T_REDIR/M_REDIR.
- Reset mid-sequence: abort to IDLE next edge; no redirect; partially written CSRs are reset by the CSR file itself (shared rst).
- Unknown/illegal state encoding -> IDLE.

Test Plan:
- Reset: hold rst 2 cycles -> ready=1, csr_wr_en=0, redirect_valid=0; CSR mstatus reads 0x1800.
- Trap: mstatus=0x1808, mtvec=0x80001000; trap_req with pc=0x80000010, cause=11 -> cycles 1/2/3 write mepc=0x80000010, mcause=0xB, mstatus=0x1880; cycle 4 redirect_valid=1, redirect_pc=0x80001000; ready low cycles 1-4.
- Mret: mepc=0x80000014, mstatus=0x1880 -> cycle 1 writes mstatus=0x1888; cycle 2 redirect_pc=0x80000014, single-cycle pulse.
- Software path: in IDLE write mtvec=0x80001003 -> read back 0x80001003; subsequent trap redirects to 0x80001000. sw_wr_en during T_CAUSE -> no write, mtvec unchanged.
- Simultaneous trap_req+mret_req+sw_wr_en(mepc=0x1234) -> software write lands, trap sequence runs, mepc ends = trap_pc, no mret redirect.
- rst asserted in T_STATUS -> next cycle IDLE, redirect_valid never asserted, mstatus=0x1800.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the machine-mode CSR file write port and read address.
// It passes software CSR accesses through while idle. Trap entry and mret run
// as short CSR update sequences that end in a one-cycle PC redirect to fetch.
module csr_trap_ctrl #(
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        wr_clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    input  logic        sw_wr_en,
    input  logic [11:0] sw_wr_reg,
    input  logic [31:0] sw_wr_bus,
    input  logic [11:0] sw_rd_reg,
    output logic [31:0] sw_rd_bus,
    output logic        ready,
    output logic        csr_wr_en,
    output logic [11:0] csr_wr_reg,
    output logic [31:0] csr_wr_bus,
    output logic [11:0] csr_rd_reg,
    input  logic [31:0] csr_rd_bus,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_STATUS = 3'd3,
        T_REDIR  = 3'd4,
        M_STATUS = 3'd5,
        M_REDIR  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M-mode.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
        logic [31:0] r;
        r        = old;
        r[7]     = old[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP stays M-mode (only mode implemented).
    function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
        logic [31:0] r;
        r        = old;
        r[3]     = old[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // State and latched trap information registers.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state: trap has priority over mret; an mret lost to a trap is dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (trap_req) begin
                    pc_d    = trap_pc;
                    cause_d = trap_cause;
                    state_d = T_EPC;
                end else if (mret_req) begin
                    state_d = M_STATUS;
                end
            end
            T_EPC:    state_d = T_CAUSE;
            T_CAUSE:  state_d = T_STATUS;
            T_STATUS: state_d = T_REDIR;
            T_REDIR:  state_d = IDLE;
            M_STATUS: state_d = M_REDIR;
            M_REDIR:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs: software passthrough while idle, otherwise the sequence drives the CSR ports.
    always_comb begin
        ready          = 1'b0;
        csr_wr_en      = 1'b0;
        csr_wr_reg     = '0;
        csr_wr_bus     = '0;
        csr_rd_reg     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            IDLE: begin
                ready      = 1'b1;
                csr_wr_en  = sw_wr_en;
                csr_wr_reg = sw_wr_reg;
                csr_wr_bus = sw_wr_bus;
                csr_rd_reg = sw_rd_reg;
            end
            T_EPC: begin
                csr_wr_en  = 1'b1;
                csr_wr_reg = MEPC_ADDR;
                csr_wr_bus = pc_q;
            end
            T_CAUSE: begin
                csr_wr_en  = 1'b1;
                csr_wr_reg = MCAUSE_ADDR;
                csr_wr_bus = cause_q;
            end
            T_STATUS: begin
                csr_rd_reg = MSTATUS_ADDR;
                csr_wr_en  = 1'b1;
                csr_wr_reg = MSTATUS_ADDR;
                csr_wr_bus = trap_mstatus(csr_rd_bus);
            end
            T_REDIR: begin
                // Direct mode only: mtvec mode bits are masked off.
                csr_rd_reg     = MTVEC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rd_bus[31:2], 2'b00};
            end
            M_STATUS: begin
                csr_rd_reg = MSTATUS_ADDR;
                csr_wr_en  = 1'b1;
                csr_wr_reg = MSTATUS_ADDR;
                csr_wr_bus = mret_mstatus(csr_rd_bus);
            end
            M_REDIR: begin
                csr_rd_reg     = MEPC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rd_bus;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign sw_rd_bus = csr_rd_bus;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed testbench for csr_trap_ctrl with a small behavioural CSR file attached.
module tb_csr_trap_ctrl;

    logic        wr_clk = 1'b0;
    logic        rst;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_req;
    logic        sw_wr_en;
    logic [11:0] sw_wr_reg;
    logic [31:0] sw_wr_bus;
    logic [11:0] sw_rd_reg;
    logic [31:0] sw_rd_bus;
    logic        ready;
    logic        csr_wr_en;
    logic [11:0] csr_wr_reg;
    logic [31:0] csr_wr_bus;
    logic [11:0] csr_rd_reg;
    logic [31:0] csr_rd_bus;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 wr_clk = ~wr_clk;

    csr_trap_ctrl dut (
        .wr_clk         (wr_clk),
        .rst            (rst),
        .trap_req       (trap_req),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .mret_req       (mret_req),
        .sw_wr_en       (sw_wr_en),
        .sw_wr_reg      (sw_wr_reg),
        .sw_wr_bus      (sw_wr_bus),
        .sw_rd_reg      (sw_rd_reg),
        .sw_rd_bus      (sw_rd_bus),
        .ready          (ready),
        .csr_wr_en      (csr_wr_en),
        .csr_wr_reg     (csr_wr_reg),
        .csr_wr_bus     (csr_wr_bus),
        .csr_rd_reg     (csr_rd_reg),
        .csr_rd_bus     (csr_rd_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Behavioural CSR file: combinational read, write at the clock edge, shared reset.
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    always @(posedge wr_clk) begin
        if (rst) begin
            m_mstatus <= 32'h0000_1800;
            m_mtvec   <= 32'h0;
            m_mepc    <= 32'h0;
            m_mcause  <= 32'h0;
        end else if (csr_wr_en) begin
            case (csr_wr_reg)
                12'h300: m_mstatus <= csr_wr_bus;
                12'h305: m_mtvec   <= csr_wr_bus;
                12'h341: m_mepc    <= csr_wr_bus;
                12'h342: m_mcause  <= csr_wr_bus;
                default: ;
            endcase
        end
    end

    assign csr_rd_bus = (csr_rd_reg == 12'h300) ? m_mstatus :
                        (csr_rd_reg == 12'h305) ? m_mtvec   :
                        (csr_rd_reg == 12'h341) ? m_mepc    :
                        (csr_rd_reg == 12'h342) ? m_mcause  : 32'h0;

    // Records any redirect pulse while armed.
    logic watch_redir = 1'b0;
    logic saw_redir   = 1'b0;
    always @(posedge wr_clk) begin
        if (watch_redir && redirect_valid) saw_redir <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs set after this hold for the coming rising edge.
    task automatic cyc();
        @(negedge wr_clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
        cyc();
        sw_wr_en  = 1'b1;
        sw_wr_reg = a;
        sw_wr_bus = d;
        settle();
        chk("sw_wr_passthru_en", {31'b0, csr_wr_en}, 32'h1);
        chk("sw_wr_passthru_reg", {20'b0, csr_wr_reg}, {20'b0, a});
        cyc();
        sw_wr_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        trap_req   = 1'b0;
        trap_pc    = '0;
        trap_cause = '0;
        mret_req   = 1'b0;
        sw_wr_en   = 1'b0;
        sw_wr_reg  = '0;
        sw_wr_bus  = '0;
        sw_rd_reg  = 12'h300;

        // Reset held for two cycles
        cyc(); cyc(); settle();
        chk("rst_ready", {31'b0, ready}, 32'h1);
        chk("rst_wr_en", {31'b0, csr_wr_en}, 32'h0);
        chk("rst_redir_v", {31'b0, redirect_valid}, 32'h0);
        chk("rst_redir_pc", redirect_pc, 32'h0);
        cyc();
        rst = 1'b0;
        settle();
        chk("post_rst_ready", {31'b0, ready}, 32'h1);
        chk("post_rst_mstatus", sw_rd_bus, 32'h0000_1800);

        // Trap entry
        sw_write(12'h300, 32'h0000_1808);
        sw_write(12'h305, 32'h8000_1000);
        trap_req   = 1'b1;
        trap_pc    = 32'h8000_0010;
        trap_cause = 32'd11;
        settle();
        chk("trap_c0_ready", {31'b0, ready}, 32'h1);
        cyc();
        trap_req = 1'b0;
        settle();
        chk("trap_c1_ready", {31'b0, ready}, 32'h0);
        chk("trap_c1_wr_en", {31'b0, csr_wr_en}, 32'h1);
        chk("trap_c1_reg", {20'b0, csr_wr_reg}, 32'h341);
        chk("trap_c1_bus", csr_wr_bus, 32'h8000_0010);
        cyc(); settle();
        chk("trap_c2_reg", {20'b0, csr_wr_reg}, 32'h342);
        chk("trap_c2_bus", csr_wr_bus, 32'h0000_000B);
        chk("trap_c2_redir_v", {31'b0, redirect_valid}, 32'h0);
        cyc(); settle();
        chk("trap_c3_reg", {20'b0, csr_wr_reg}, 32'h300);
        chk("trap_c3_bus", csr_wr_bus, 32'h0000_1880);
        cyc(); settle();
        chk("trap_c4_redir_v", {31'b0, redirect_valid}, 32'h1);
        chk("trap_c4_redir_pc", redirect_pc, 32'h8000_1000);
        chk("trap_c4_wr_en", {31'b0, csr_wr_en}, 32'h0);
        chk("trap_c4_ready", {31'b0, ready}, 32'h0);
        cyc(); settle();
        chk("trap_c5_redir_v", {31'b0, redirect_valid}, 32'h0);
        chk("trap_c5_redir_pc", redirect_pc, 32'h0);
        chk("trap_c5_ready", {31'b0, ready}, 32'h1);
        chk("trap_mepc", m_mepc, 32'h8000_0010);
        chk("trap_mcause", m_mcause, 32'h0000_000B);
        chk("trap_mstatus", m_mstatus, 32'h0000_1880);

        // mret
        sw_write(12'h341, 32'h8000_0014);
        mret_req = 1'b1;
        cyc();
        mret_req = 1'b0;
        settle();
        chk("mret_c1_reg", {20'b0, csr_wr_reg}, 32'h300);
        chk("mret_c1_bus", csr_wr_bus, 32'h0000_1888);
        chk("mret_c1_redir_v", {31'b0, redirect_valid}, 32'h0);
        cyc(); settle();
        chk("mret_c2_redir_v", {31'b0, redirect_valid}, 32'h1);
        chk("mret_c2_redir_pc", redirect_pc, 32'h8000_0014);
        chk("mret_c2_wr_en", {31'b0, csr_wr_en}, 32'h0);
        cyc(); settle();
        chk("mret_c3_redir_v", {31'b0, redirect_valid}, 32'h0);
        chk("mret_c3_ready", {31'b0, ready}, 32'h1);
        chk("mret_mstatus", m_mstatus, 32'h0000_1888);

        // Software mtvec write, read back, then trap uses aligned base; sw write blocked mid-sequence
        sw_write(12'h305, 32'h8000_1003);
        sw_rd_reg = 12'h305;
        settle();
        chk("sw_rd_mtvec", sw_rd_bus, 32'h8000_1003);
        trap_req   = 1'b1;
        trap_pc    = 32'h8000_0020;
        trap_cause = 32'd2;
        cyc();
        trap_req = 1'b0;
        cyc();
        sw_wr_en  = 1'b1;
        sw_wr_reg = 12'h305;
        sw_wr_bus = 32'hDEAD_0000;
        settle();
        chk("blk_c2_reg", {20'b0, csr_wr_reg}, 32'h342);
        chk("blk_c2_bus", csr_wr_bus, 32'h0000_0002);
        cyc();
        sw_wr_en = 1'b0;
        settle();
        chk("blk_c3_sw_rd_bus", sw_rd_bus, 32'h0000_1888);
        chk("blk_c3_bus", csr_wr_bus, 32'h0000_1880);
        cyc(); settle();
        chk("blk_c4_redir_pc", redirect_pc, 32'h8000_1000);
        cyc(); settle();
        chk("blk_mtvec", m_mtvec, 32'h8000_1003);

        // Simultaneous trap + mret + software write
        trap_req   = 1'b1;
        mret_req   = 1'b1;
        trap_pc    = 32'h8000_0030;
        trap_cause = 32'd3;
        sw_wr_en   = 1'b1;
        sw_wr_reg  = 12'h341;
        sw_wr_bus  = 32'h0000_1234;
        settle();
        chk("sim_c0_wr_en", {31'b0, csr_wr_en}, 32'h1);
        cyc();
        trap_req = 1'b0;
        mret_req = 1'b0;
        sw_wr_en = 1'b0;
        settle();
        chk("sim_sw_landed", m_mepc, 32'h0000_1234);
        chk("sim_c1_reg", {20'b0, csr_wr_reg}, 32'h341);
        cyc(); cyc(); cyc(); settle();
        chk("sim_c4_redir_pc", redirect_pc, 32'h8000_1000);
        cyc(); settle();
        watch_redir = 1'b1;
        chk("sim_mepc", m_mepc, 32'h8000_0030);
        cyc(); cyc(); cyc(); settle();
        chk("sim_no_mret", {31'b0, saw_redir}, 32'h0);
        watch_redir = 1'b0;

        // Reset during T_STATUS
        trap_req   = 1'b1;
        trap_pc    = 32'h8000_0040;
        trap_cause = 32'd4;
        cyc();
        trap_req    = 1'b0;
        watch_redir = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        settle();
        chk("rmid_in_status", {20'b0, csr_wr_reg}, 32'h300);
        cyc();
        rst = 1'b0;
        sw_rd_reg = 12'h300;
        settle();
        chk("rmid_ready", {31'b0, ready}, 32'h1);
        chk("rmid_mstatus", sw_rd_bus, 32'h0000_1800);
        cyc(); cyc(); cyc(); settle();
        chk("rmid_no_redir", {31'b0, saw_redir}, 32'h0);
        chk("rmid_ready_late", {31'b0, ready}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
